// File: rtl/if_prefetch_queue_pkg.sv
// Shared definitions for the instruction-fetch prefetch queue.
package if_prefetch_queue_pkg;

  localparam int          XLEN    = 64;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          ENTRY_W = 32 + XLEN;

  typedef enum logic {
    RUN  = 1'b0,
    DROP = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with flush; head is read combinationally from registered storage.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int             AW  = $clog2(DEPTH);
  localparam logic [AW:0]    CAP = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Flush wins; pushes beyond capacity and pops from empty are ignored.
  assign do_push = push && !flush && (count < CAP);
  assign do_pop  = pop && !flush && (count != '0);

  // Pointer and occupancy tracking.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage, not reset: occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, buffers returned words
// for decode, and handles redirects including a response still in flight.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [63:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [63:0]            redirect_pc,
  input  logic                   dec_ready,
  output logic                   dec_valid,
  output logic [31:0]            dec_instr,
  output logic [63:0]            dec_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   fetch_pc_nxt;
  logic [XLEN-1:0]   drop_addr;
  logic [XLEN-1:0]   drop_addr_nxt;
  logic [CW-1:0]     fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic              room;
  logic              req_int;
  logic              push;
  logic              pop;
  logic              fifo_valid;

  assign room = fifo_count < CW'(DEPTH);

  // Next-state, fetch address and push decision.
  always_comb begin
    state_nxt     = state;
    fetch_pc_nxt  = fetch_pc;
    drop_addr_nxt = drop_addr;
    req_int       = 1'b0;
    push          = 1'b0;
    case (state)
      RUN: begin
        req_int = room;
        if (redirect) begin
          fetch_pc_nxt = redirect_pc;
          // A request left without its ack must still be drained.
          if (req_int && !imem_ack) begin
            state_nxt     = DROP;
            drop_addr_nxt = fetch_pc;
          end
        end else if (req_int && imem_ack) begin
          push         = 1'b1;
          fetch_pc_nxt = fetch_pc + 64'd4;
        end
      end
      DROP: begin
        // Hold the stale request until its response arrives, then discard it.
        req_int = 1'b1;
        if (imem_ack) state_nxt = RUN;
        if (redirect) fetch_pc_nxt = redirect_pc;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Control state: FSM and fetch address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  // Address of the request being drained in DROP.
  always_ff @(posedge clock) begin
    drop_addr <= drop_addr_nxt;
  end

  assign fifo_valid = (fifo_count != '0);
  assign pop        = fifo_valid && dec_ready && !redirect;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data ({imem_rdata, fetch_pc}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign imem_req  = req_int && !reset;
  assign imem_addr = (state == DROP) ? drop_addr : fetch_pc;
  assign dec_valid = fifo_valid && !reset;
  assign dec_instr = dec_valid ? fifo_head[ENTRY_W-1:XLEN] : NOP;
  assign dec_pc    = dec_valid ? fifo_head[XLEN-1:0] : '0;
  assign count     = reset ? '0 : fifo_count;

endmodule
